// File: rtl/state_ram.sv
// Dual-port state array with a self-clearing fill engine.
// Clears on reset and on request; the array is owned by the engine while busy.
module state_ram #(
  parameter int             DW      = 2,
  parameter int             AW      = 14,
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_drop
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        r_state;
  logic [AW-1:0] r_clr_addr;
  logic          r_busy;
  logic          r_drop;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  logic          w_idle;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic          w_rd_acc;
  logic          w_rd_hit;

  assign w_idle   = (r_state == IDLE);
  assign w_rd_acc = w_idle && rd_en;
  assign w_rd_hit = wr_en && (wr_addr == rd_addr);

  // single write port shared by user writes and the fill engine
  assign w_we    = !rst && (w_idle ? wr_en : 1'b1);
  assign w_waddr = w_idle ? wr_addr : r_clr_addr;
  assign w_wdata = w_idle ? wr_data : CLR_VAL;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // write-first bypass on a same-address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_data  <= w_rd_hit ? wr_data : r_mem[rd_addr];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= !w_idle && wr_en;
      unique case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
          end
        end
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = r_busy;
  assign wr_drop  = r_drop;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_state_ram.sv
// Scoreboard bench for state_ram: reference model predicts reads,
// busy and drop flags; read results are queued and popped on rd_valid.
module tb_state_ram;

  localparam int            DW    = 2;
  localparam int            AW    = 4;
  localparam int            DEPTH = 16;
  localparam logic [DW-1:0] CLR   = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          clr_busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_drop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_ca;
  logic [DW-1:0] m_last;
  logic [DW-1:0] exp_q [$];

  state_ram #(.DW(DW), .AW(AW), .CLR_VAL(CLR)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_in();
    rst     = 1'b0;
    clr_req = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  // one clock: advance the model with the driven inputs, then check
  task automatic cyc();
    bit            pushed;
    bit            exp_drop;
    logic [DW-1:0] rv;
    logic [DW-1:0] e;
    pushed   = 0;
    exp_drop = 0;
    @(posedge clk);
    if (rst) begin
      m_busy = 1;
      m_ca   = 0;
      m_last = '0;
      exp_q.delete();
    end else if (m_busy) begin
      m_mem[m_ca] = CLR;
      exp_drop    = wr_en;
      if (m_ca == DEPTH - 1) begin
        m_busy = 0;
        m_ca   = 0;
      end else begin
        m_ca++;
      end
    end else begin
      if (rd_en) begin
        rv = (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
        exp_q.push_back(rv);
        pushed = 1;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        m_busy = 1;
        m_ca   = 0;
      end
    end
    #1;
    chk("clr_busy", 32'(clr_busy), 32'(m_busy));
    chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
    chk("rd_valid", 32'(rd_valid), 32'(pushed));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e));
        m_last = e;
      end
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(m_last));
    end
  endtask

  task automatic count_busy(input string tag, input int pulse_at);
    int n;
    n = 0;
    while (clr_busy && n < 40) begin
      clr_req = (n == pulse_at);
      cyc();
      n++;
    end
    clr_req = 1'b0;
    chk(tag, 32'(n), 32'(16));
  endtask

  task automatic rd(input logic [AW-1:0] a);
    idle_in();
    rd_en   = 1'b1;
    rd_addr = a;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1;
    m_ca   = 0;
    m_last = '0;
    idle_in();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    count_busy("reset_clear_len", -1);

    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle_in();
    cyc();

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 2'd3;
    cyc();
    rd(4'd5);
    idle_in();
    repeat (3) cyc();

    idle_in();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 2'd1;
    rd_en = 1'b1; rd_addr = 4'd7;
    cyc();
    wr_addr = 4'd9; wr_data = 2'd0; rd_addr = 4'd5;
    cyc();
    rd(4'd9);
    idle_in();
    cyc();

    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en   = (i % 2 == 0);
      wr_addr = 4'd0;
      wr_data = 2'd1;
      rd_en   = 1'b1;
      rd_addr = 4'd0;
      cyc();
    end
    idle_in();
    for (int i = 0; i < 30 && m_busy; i++) cyc();
    rd(4'd0);

    idle_in();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_busy("rst_mid_clear_len", -1);

    idle_in();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 2'd1;
    cyc();
    rd(4'd3);
    idle_in();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 2'd1;
    rd_en = 1'b1; rd_addr = 4'd3;
    clr_req = 1'b1;
    cyc();
    idle_in();
    count_busy("clr_req_ignored_len", 5);
    rd(4'd3);

    for (int i = 0; i < 200; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      clr_req = ($urandom_range(0, 49) == 0);
      rd_en   = $urandom_range(0, 1) != 0;
      wr_en   = $urandom_range(0, 1) != 0;
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = DW'($urandom_range(0, 3));
      cyc();
    end
    idle_in();
    for (int i = 0; i < 40 && m_busy; i++) cyc();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle_in();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
